spectrum_peak_finder: RTL

Parametrised per-range-bin spectral peak search for the lidar power-spectrum stream. Consumes one FFT power spectrum per range bin (N = 2^ADDR_W samples, address-ordered), finds the maximum inside a run-time search window, and emits peak value, address, both neighbour samples (for three-point interpolation), range-bin index and a threshold-hit flag once per spectrum. Sits between the power-spectrum accumulator and the Doppler/velocity estimator.

---
 rtl/spectrum_peak_finder_pkg.sv | 20 ++
 rtl/spectrum_peak_finder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_finder_pkg.sv
// -----------------------------------------------------------------------------
// peak_pkg
// Shared definitions for the lidar spectrum chain (power-spectrum accumulator,
// peak finder, Doppler/velocity estimator).
//   - state_e      : peak-finder frame state (IDLE, SEARCH)
//   - PEAK_*       : default widths/sizes shared by the blocks of the chain
// -----------------------------------------------------------------------------
package peak_pkg;

    localparam int PEAK_DATA_W   = 32;  // power sample width, unsigned
    localparam int PEAK_ADDR_W   = 10;  // spectrum address width (N = 2^ADDR_W)
    localparam int PEAK_BIN_W    = 5;   // range-bin index width
    localparam int PEAK_NUM_BINS = 32;  // range bins per shot

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_e;

endpackage

// File: rtl/spectrum_peak_finder.sv
// -----------------------------------------------------------------------------
// spectrum_peak_finder
// Per-range-bin peak search over one FFT power spectrum (N = 2^ADDR_W samples,
// address ordered). Finds the first maximum inside [win_lo, win_hi], and
// reports it with both neighbour samples, the range-bin index and a threshold
// hit flag once per spectrum.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   en                search enable; low aborts the frame and clears bin count
//   win_lo/win_hi     inclusive search window, sampled with the addr-0 sample
//   thresh            hit threshold, sampled with the addr-0 sample
//   s_valid/s_addr/s_data   sample stream
//   pk_valid          one-cycle result strobe
//   pk_value/pk_addr/pk_left/pk_right/pk_bin/pk_hit   result fields (held)
//   seq_err           one-cycle pulse on an out-of-sequence sample address
// -----------------------------------------------------------------------------
module spectrum_peak_finder
    import peak_pkg::*;
#(
    parameter int DATA_W   = PEAK_DATA_W,
    parameter int ADDR_W   = PEAK_ADDR_W,
    parameter int BIN_W    = PEAK_BIN_W,
    parameter int NUM_BINS = PEAK_NUM_BINS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] win_lo,
    input  logic [ADDR_W-1:0] win_hi,
    input  logic [DATA_W-1:0] thresh,
    input  logic              s_valid,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    output logic              pk_valid,
    output logic [DATA_W-1:0] pk_value,
    output logic [ADDR_W-1:0] pk_addr,
    output logic [DATA_W-1:0] pk_left,
    output logic [DATA_W-1:0] pk_right,
    output logic [BIN_W-1:0]  pk_bin,
    output logic              pk_hit,
    output logic              seq_err
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [BIN_W-1:0]  BIN_LAST  = BIN_W'(NUM_BINS - 1);

    state_e state_q, state_d;

    // frame context
    logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, next_addr_q, next_addr_d;
    logic [DATA_W-1:0] thr_q, thr_d, prev_q, prev_d;
    logic [DATA_W-1:0] max_q, max_d, left_q, left_d, right_q, right_d;
    logic [ADDR_W-1:0] max_addr_q, max_addr_d;
    logic              pend_q, pend_d;
    logic [BIN_W-1:0]  bin_q, bin_d;

    // registered outputs
    logic              pk_valid_q, pk_valid_d, pk_hit_q, pk_hit_d;
    logic              seq_err_q, seq_err_d;
    logic [DATA_W-1:0] pk_value_q, pk_value_d, pk_left_q, pk_left_d;
    logic [DATA_W-1:0] pk_right_q, pk_right_d;
    logic [ADDR_W-1:0] pk_addr_q, pk_addr_d;
    logic [BIN_W-1:0]  pk_bin_q, pk_bin_d;

    // per-sample working values: _e = effective context, _b = base, _n = updated
    logic [ADDR_W-1:0] lo_e, hi_e, max_addr_b, max_addr_n;
    logic [DATA_W-1:0] thr_e, max_b, left_b, right_b, prev_b;
    logic [DATA_W-1:0] max_n, left_n, right_n;
    logic              pend_b, pend_n;

    logic accept, start, in_seq, err, proc, last;

    assign accept = en & s_valid;
    // IDLE silently ignores samples until an addr-0 sample opens a frame
    assign start  = accept && (state_q == ST_IDLE) && (s_addr == '0);
    assign in_seq = accept && (state_q == ST_SEARCH) && (s_addr == next_addr_q);
    assign err    = accept && (state_q == ST_SEARCH) && (s_addr != next_addr_q);
    assign proc   = start | in_seq;
    assign last   = (s_addr == ADDR_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            thr_q       <= '0;
            next_addr_q <= '0;
            prev_q      <= '0;
            max_q       <= '0;
            max_addr_q  <= '0;
            left_q      <= '0;
            right_q     <= '0;
            pend_q      <= 1'b0;
            bin_q       <= '0;
            pk_valid_q  <= 1'b0;
            pk_value_q  <= '0;
            pk_addr_q   <= '0;
            pk_left_q   <= '0;
            pk_right_q  <= '0;
            pk_bin_q    <= '0;
            pk_hit_q    <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            thr_q       <= thr_d;
            next_addr_q <= next_addr_d;
            prev_q      <= prev_d;
            max_q       <= max_d;
            max_addr_q  <= max_addr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            pend_q      <= pend_d;
            bin_q       <= bin_d;
            pk_valid_q  <= pk_valid_d;
            pk_value_q  <= pk_value_d;
            pk_addr_q   <= pk_addr_d;
            pk_left_q   <= pk_left_d;
            pk_right_q  <= pk_right_d;
            pk_bin_q    <= pk_bin_d;
            pk_hit_q    <= pk_hit_d;
            seq_err_q   <= seq_err_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (!en || err) begin
            state_d = ST_IDLE;
        end else if (proc) begin
            // the last sample closes the frame; the next addr-0 sample may follow
            // immediately with no dead cycle
            state_d = last ? ST_IDLE : ST_SEARCH;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        // an addr-0 sample starts from fresh context and the live window inputs
        lo_e       = start ? win_lo : lo_q;
        hi_e       = start ? win_hi : hi_q;
        thr_e      = start ? thresh : thr_q;
        max_b      = start ? '0     : max_q;
        max_addr_b = start ? win_lo : max_addr_q;
        left_b     = start ? '0     : left_q;
        right_b    = start ? '0     : right_q;
        pend_b     = start ? 1'b0   : pend_q;
        prev_b     = start ? '0     : prev_q;

        max_n      = max_b;
        max_addr_n = max_addr_b;
        left_n     = left_b;
        right_n    = right_b;
        pend_n     = pend_b;

        // strict compare keeps the first of equal maxima; a new maximum right
        // after the old one takes the old one as its left neighbour
        if ((s_addr >= lo_e) && (s_addr <= hi_e) && (s_data > max_b)) begin
            max_n      = s_data;
            max_addr_n = s_addr;
            left_n     = prev_b;
            right_n    = '0;
            pend_n     = 1'b1;
        end else if (pend_b) begin
            right_n = s_data;
            pend_n  = 1'b0;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        lo_d        = lo_q;
        hi_d        = hi_q;
        thr_d       = thr_q;
        next_addr_d = next_addr_q;
        prev_d      = prev_q;
        max_d       = max_q;
        max_addr_d  = max_addr_q;
        left_d      = left_q;
        right_d     = right_q;
        pend_d      = pend_q;
        bin_d       = bin_q;
        pk_valid_d  = 1'b0;
        pk_value_d  = pk_value_q;
        pk_addr_d   = pk_addr_q;
        pk_left_d   = pk_left_q;
        pk_right_d  = pk_right_q;
        pk_bin_d    = pk_bin_q;
        pk_hit_d    = pk_hit_q;
        seq_err_d   = err;

        if (!en) begin
            bin_d = '0;
        end else if (proc) begin
            lo_d        = lo_e;
            hi_d        = hi_e;
            thr_d       = thr_e;
            next_addr_d = s_addr + 1'b1;
            prev_d      = s_data;
            max_d       = max_n;
            max_addr_d  = max_addr_n;
            left_d      = left_n;
            right_d     = right_n;
            pend_d      = pend_n;
            if (last) begin
                pk_valid_d = 1'b1;
                pk_value_d = max_n;
                pk_addr_d  = max_addr_n;
                pk_left_d  = left_n;
                pk_right_d = right_n;
                pk_bin_d   = bin_q;
                pk_hit_d   = (max_n > thr_e);
                bin_d      = (bin_q == BIN_LAST) ? '0 : bin_q + 1'b1;
            end
        end
    end

    assign pk_valid = pk_valid_q;
    assign pk_value = pk_value_q;
    assign pk_addr  = pk_addr_q;
    assign pk_left  = pk_left_q;
    assign pk_right = pk_right_q;
    assign pk_bin   = pk_bin_q;
    assign pk_hit   = pk_hit_q;
    assign seq_err  = seq_err_q;

endmodule
